// File: rtl/rv_pkg.sv
// Shared defaults and types for the RV32IM integer register file.
package rv_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  localparam int unsigned REG_ZERO = 0;

  typedef logic [AW_DEF-1:0] reg_addr_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered
// popcount of the busy vector.
module rf_scoreboard
  import rv_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             we0_i,
  input  logic [AW-1:0]    waddr0_i,
  input  logic             we1_i,
  input  logic [AW-1:0]    waddr1_i,
  input  logic             issue_en_i,
  input  logic [AW-1:0]    issue_rd_i,
  input  logic             flush_i,
  output logic [NREGS-1:0] busy_o,
  output logic [AW:0]      pending_cnt_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;

  // Priority per register: flush, then a fresh issue (newer producer), then writeback.
  always_comb begin
    busy_d    = busy_q;
    busy_d[0] = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      if (flush_i)
        busy_d[r] = 1'b0;
      else if (issue_en_i && (issue_rd_i == AW'(r)))
        busy_d[r] = 1'b1;
      else if ((we0_i && (waddr0_i == AW'(r))) || (we1_i && (waddr1_i == AW'(r))))
        busy_d[r] = 1'b0;
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int r = 0; r < NREGS; r++)
      cnt_d = cnt_d + (AW+1)'(busy_d[r]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o        = busy_q;
  assign pending_cnt_o = cnt_q;

endmodule

// File: rtl/rv_regfile_sb.sv
// Two-write, NREAD-read integer register file with write-to-read bypass and
// a pending-write scoreboard for ID-stage hazard detection.
module rv_regfile_sb
  import rv_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NREAD = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [NREAD*AW-1:0]   RADDR,
  output logic [NREAD*XLEN-1:0] RDATA,
  output logic [NREAD-1:0]      RBUSY,
  input  logic                  WE0,
  input  logic [AW-1:0]         WADDR0,
  input  logic [XLEN-1:0]       WDATA0,
  input  logic                  WE1,
  input  logic [AW-1:0]         WADDR1,
  input  logic [XLEN-1:0]       WDATA1,
  input  logic                  ISSUE_EN,
  input  logic [AW-1:0]         ISSUE_RD,
  input  logic                  FLUSH,
  output logic [AW:0]           PENDING_CNT
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy;

  // Port 1 is assigned last so the MDU wins a same-address collision.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      for (int r = 0; r < NREGS; r++)
        regs_q[r] <= '0;
    end else begin
      if (WE0 && (WADDR0 != AW'(REG_ZERO)))
        regs_q[WADDR0] <= WDATA0;
      if (WE1 && (WADDR1 != AW'(REG_ZERO)))
        regs_q[WADDR1] <= WDATA1;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            hit0, hit1, is_zero;
    logic [XLEN-1:0] rd;

    assign ra      = RADDR[i*AW +: AW];
    assign is_zero = (ra == AW'(REG_ZERO));
    assign hit1    = WE1 && (WADDR1 == ra);
    assign hit0    = WE0 && (WADDR0 == ra);

    always_comb begin
      if (is_zero)   rd = '0;
      else if (hit1) rd = WDATA1;
      else if (hit0) rd = WDATA0;
      else           rd = regs_q[ra];
    end

    assign RDATA[i*XLEN +: XLEN] = rd;
    assign RBUSY[i] = busy[ra] && !(hit0 || hit1) && !is_zero;
  end

  rf_scoreboard #(
    .NREGS(NREGS),
    .AW   (AW)
  ) u_sb (
    .clk_i        (CLK),
    .rst_n_i      (RESET_N),
    .we0_i        (WE0),
    .waddr0_i     (WADDR0),
    .we1_i        (WE1),
    .waddr1_i     (WADDR1),
    .issue_en_i   (ISSUE_EN),
    .issue_rd_i   (ISSUE_RD),
    .flush_i      (FLUSH),
    .busy_o       (busy),
    .pending_cnt_o(PENDING_CNT)
  );

endmodule

// File: doc/rv_regfile_sb.md
Name: rv_regfile_sb

Overview:
Parametrised successor to the single-write, two-read integer register file, with a pending-write scoreboard.
- Provides NREAD combinational read ports with write-to-read bypass.
- Provides two write ports: WB pipeline writeback (port 0) and long-latency MUL/DIV writeback (port 1).
- Tracks a per-register busy bit that the ID stage uses for hazard stalls.
- Sits between ID (reads, issue marking) and WB/MDU (writes) in the RV32IM pipeline.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers; register 0 is hardwired to zero
NREAD, 2, number of read ports
AW, $clog2(NREGS), register address width (derived, not overridden)

Ports:
CLK  in  1  clock; all state updates on rising edge
RESET_N  in  1  synchronous active-low reset
RADDR  in  NREAD*AW  read addresses; port i occupies bits [i*AW +: AW]
RDATA  out  NREAD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN]
RBUSY  out  NREAD  per-port flag: read register has an outstanding write
WE0  in  1  write enable, WB port
WADDR0  in  AW  write address, WB port
WDATA0  in  XLEN  write data, WB port
WE1  in  1  write enable, MDU port
WADDR1  in  AW  write address, MDU port
WDATA1  in  XLEN  write data, MDU port
ISSUE_EN  in  1  mark ISSUE_RD as pending
ISSUE_RD  in  AW  destination register of the issued instruction
FLUSH  in  1  clear all busy bits (pipeline flush)
PENDING_CNT  out  AW+1  registered count of busy registers

Behaviour:
- Reset, sampled on a CLK edge while RESET_N=0:
  - All NREGS registers become 0, all busy bits 0, PENDING_CNT=0.
  - Writes, issues and flushes in that cycle are ignored.
  - Reset mid-operation discards everything in flight.
- Write:
  - On a rising edge, if WEk=1 and WADDRk!=0, reg[WADDRk] <= WDATAk.
  - Writes to address 0 are dropped.
  - Both ports writing the same address in one cycle: port 1 (MDU) wins.
- Read is combinational, zero latency.
  - RADDR=0 returns 0.
  - Otherwise bypass applies: if WE1 and WADDR1==RADDR, return WDATA1; else if WE0 and WADDR0==RADDR, return WDATA0; else return reg[RADDR].
  - Bypass priority matches write priority.
- Scoreboard, one busy bit per register; bit 0 is constant 0.
  - Next state per register r: if FLUSH, 0; else if ISSUE_EN and ISSUE_RD==r and r!=0, 1; else if (WE0 and WADDR0==r) or (WE1 and WADDR1==r), 0; else hold.
  - Issue and write to the same register in one cycle: issue wins (the newer producer stays pending).
  - FLUSH together with ISSUE_EN: FLUSH wins and the issue is dropped.
  - Issue to an already-busy register: stays 1 (no counting of multiple producers).
- RBUSY[i] = busy[RADDR_i] AND NOT (a write to RADDR_i in the current cycle).
  - The register clears combinationally on writeback, consistent with the bypass.
  - RBUSY for RADDR=0 is always 0.
- PENDING_CNT:
  - Registered popcount of the busy vector, so it reflects the vector after the edge: valid one cycle after any change.
  - Range 0..NREGS-1; no overflow is possible.
- RDATA and RBUSY are purely combinational from RADDR, the write ports and state. No latches.

Decomposition:
- Shared package rv_pkg holds:
  - XLEN and NREGS defaults.
  - Constant REG_ZERO = 0.
  - A reg-address typedef sized by AW.
- One natural sub-module, rf_scoreboard: busy vector, issue/clear/flush priority and PENDING_CNT.
- The top module holds the storage array, write priority and the bypass muxes.

Test Plan:
- Reset and read: hold RESET_N=0 for one edge, then read RADDR={5,0} -> RDATA={0,0}, RBUSY=0, PENDING_CNT=0.
- Write and bypass: WE0=1, WADDR0=3, WDATA0=A5A5A5A5, RADDR0=3 in the same cycle -> RDATA0=A5A5A5A5 before the edge; after the edge with WE0=0 -> still A5A5A5A5. Writing 0xFFFF_FFFF to address 0 -> RADDR=0 reads 0.
- Dual write conflict: WE0 writes 7<-11111111 and WE1 writes 7<-22222222 in one cycle -> bypass and stored value both 22222222.
- Scoreboard: issue rd=9, next cycle RADDR1=9 -> RBUSY1=1 and PENDING_CNT=1. Then WE1 to 9 with 5A5A5A5A -> RBUSY1=0 that cycle, RDATA1=5A5A5A5A, PENDING_CNT=0 one cycle later.
- Simultaneous issue and write to rd=4 in one cycle -> busy[4]=1 after the edge. Issue rd=0 -> busy stays 0, count unchanged.
- Flush and reset priority: issue rd=2,3,4 (count 3), then FLUSH plus ISSUE rd=6 -> all busy 0, count 0. Assert RESET_N=0 mid-sequence with WE0 active -> write dropped, all registers 0.
